tophat_pin_responder: RTL and testbench
=======================================

# tophat_pin_responder

Byte-wide command responder for the tophat TinyTapeout top, sitting directly behind the dedicated pins. It answers the pin-level initiator (cocotb bench or external MCU) driving `ui_in` plus a strobe, using a four-phase strobe/ack handshake. It decodes one-byte read and two-byte write commands into a small register port on the core, and returns read data on `uo_out`. The top instantiates it with `rst = ~rst_n`, `din = ui_in`, `stb = uio_in[0]`, `uo_out = dout`, `uio_out[1] = ack`, `uio_out[2] = err`.

## Interface
- `SYNC_STAGES`, 2: synchronizer depth on `stb` (≥2).
- `TIMEOUT`, 255: max cycles in WAIT_DATA before abort (1..255, 8-bit counter).
- `clk` in 1: single clock; all logic on rising edge.
- `rst` in 1: synchronous, active-high reset.
- `din` in 8: command/data byte from host; asynchronous to `clk`.
- `stb` in 1: host strobe; asynchronous, passed through `SYNC_STAGES` flops.
- `ack` out 1: handshake acknowledge.
- `dout` out 8: last read result; holds until next read completes.
- `err` out 1: status of last command.
- `wr_en` out 1: one-cycle register write pulse to core.
- `wr_addr` out 2, `wr_data` out 8: valid while `wr_en`=1.
- `rd_addr` out 2: register select, valid in RD_FETCH.
- `rd_data` in 8: combinational read data from core for `rd_addr`.

## Operation
- Header byte: bit7 = 1 for write, 0 for read; bits[6:2] reserved and must be 0; bits[1:0] = address.
- Edge detection: `stb_s` is the synchronized strobe. An edge is `stb_s`=1, previous `stb_s`=0, and `armed`=1. `armed` clears on reset and sets on the first cycle `stb_s`=0. A strobe held high through reset therefore produces no command.
- `din` is sampled raw on the edge cycle. The host holds `din` stable from ≥`SYNC_STAGES`+1 cycles before raising `stb` until it sees `ack`.
- States:
  - IDLE: on edge, register header.
    - Reserved bits ≠0: `err`←1, go to ACK_HDR.
    - Read: go to RD_FETCH.
    - Write: `err`←0, go to ACK_HDR.
  - RD_FETCH (1 cycle): `rd_addr`=hdr[1:0]; `dout`←`rd_data`; `err`←0; go to ACK_RD.
  - ACK_RD / ACK_HDR / ACK_DATA: `ack`=1 until `stb_s`=0, then `ack`←0 and go to:
    - IDLE from ACK_RD, ACK_DATA, or an ACK_HDR with error.
    - WAIT_DATA from a valid write ACK_HDR.
  - WAIT_DATA: counter clears on entry and increments each cycle.
    - On edge: `wr_en`=1 for one cycle with `wr_addr`=hdr[1:0], `wr_data`=`din`; go to ACK_DATA.
    - If the counter reaches `TIMEOUT` first: `err`←1, go to IDLE, no write.
- Edge and timeout in the same cycle: the edge wins and the write proceeds.
- `stb` rising while `ack`=1 is impossible under the protocol. Edges are only honoured in IDLE and WAIT_DATA.
- `err` is sticky until the next completed header; it is cleared by a valid read or write header.

## Timing
- Reset values: `ack`=0, `dout`=0x00, `err`=0, `wr_en`=0, `wr_addr`=0, `wr_data`=0, `rd_addr`=0. State is IDLE, `armed`=0, synchronizer flops and counter are 0.
- Pin `stb` rise to edge detect: `SYNC_STAGES` cycles (edge cycle N).
- Read: `rd_addr` valid at N+1; `ack`=1 and new `dout` at N+2.
- Write data byte: `wr_en` and `ack` both go high at N+1.
- Header ack (write or error): `ack`=1 at N+1.
- `ack` falls one cycle after `stb_s` is seen low, i.e. `SYNC_STAGES`+1 cycles after pin `stb` falls.
- Timeout: abort in the cycle the count equals `TIMEOUT`, i.e. `TIMEOUT`+1 cycles after entering WAIT_DATA.
- `rst` mid-command forces reset values on the next edge. No `wr_en` is issued for a partial command.

## Test plan
- Reset with `stb`=1 held, release, hold `stb` 20 cycles, then drop → no `ack`, no `wr_en`, `err`=0.
- Write 0x82 then 0x5A, each with full handshake → exactly one `wr_en` pulse with `wr_addr`=2 and `wr_data`=0x5A; `ack` rises N+1 after each edge; `err`=0.
- Core returns 0xC3 for addr 1; send read 0x01 → `rd_addr`=1 at N+1, `ack`=1 and `dout`=0xC3 at N+2; `dout` holds 0xC3 after `ack` falls.
- Header 0x24 (reserved bit set) → `ack` at N+1, `err`=1, no write, next byte treated as a header; a following valid read clears `err`.
- Write header 0x80 with no data byte, `TIMEOUT`=16 → `err`=1 after 17 cycles in WAIT_DATA, no `wr_en`, back in IDLE.
- Assert `rst` in WAIT_DATA after header 0x83 → all outputs at reset values; a later data byte is not written.

Source files
------------

// File: rtl/tophat_pin_responder.sv
// tophat_pin_responder
// Byte-wide command responder behind the TinyTapeout pins. A host drives a byte on din_i and
// raises stb_i; the block answers with a four-phase strobe/ack handshake. A one-byte header
// either reads a core register (result on dout_o) or starts a write whose data follows as a
// second strobed byte.
//
// Ports:
//   clk_i      single rising-edge clock
//   rst_i      synchronous active-high reset
//   din_i      command/data byte from host (asynchronous, held stable around stb_i)
//   stb_i      host strobe (asynchronous, synchronized internally)
//   ack_o      handshake acknowledge
//   dout_o     last read result, held until the next read completes
//   err_o      status of last command (sticky until the next valid header)
//   wr_en_o    one-cycle register write pulse to the core
//   wr_addr_o  write address, valid while wr_en_o
//   wr_data_o  write data, valid while wr_en_o
//   rd_addr_o  read register select, valid during the fetch cycle
//   rd_data_i  combinational read data from the core for rd_addr_o
module tophat_pin_responder #(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned TIMEOUT     = 255
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] din_i,
  input  logic       stb_i,
  output logic       ack_o,
  output logic [7:0] dout_o,
  output logic       err_o,
  output logic       wr_en_o,
  output logic [1:0] wr_addr_o,
  output logic [7:0] wr_data_o,
  output logic [1:0] rd_addr_o,
  input  logic [7:0] rd_data_i
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StRdFetch  = 3'd1;
  localparam logic [2:0] StAckRd    = 3'd2;
  localparam logic [2:0] StAckHdr   = 3'd3;
  localparam logic [2:0] StAckData  = 3'd4;
  localparam logic [2:0] StWaitData = 3'd5;

  localparam logic [7:0] TimeoutCnt = 8'(TIMEOUT);

  logic [SYNC_STAGES-1:0] sync_q;
  // Tracks which synchronizer stages hold a real pin sample since reset. Without it the
  // reset-zeroed chain would look like a low strobe and arm edge detection even when the
  // strobe was held high through reset.
  logic [SYNC_STAGES-1:0] fill_q;

  logic       stb_s;
  logic       stb_edge;
  logic       stb_prev_q, stb_prev_d;
  logic       armed_q, armed_d;
  logic [2:0] state_q, state_d;
  logic [7:0] hdr_q, hdr_d;
  logic [7:0] cnt_q, cnt_d;
  logic       ack_q, ack_d;
  logic [7:0] dout_q, dout_d;
  logic       err_q, err_d;
  logic       wr_en_q, wr_en_d;
  logic [1:0] wr_addr_q, wr_addr_d;
  logic [7:0] wr_data_q, wr_data_d;
  logic       hdr_is_write;

  assign stb_s        = sync_q[SYNC_STAGES-1];
  assign stb_edge     = stb_s & ~stb_prev_q & armed_q;
  assign hdr_is_write = hdr_q[7] & ~|hdr_q[6:2];

  always_comb begin
    stb_prev_d = stb_s;
    armed_d    = armed_q | (fill_q[SYNC_STAGES-1] & ~stb_s);
    state_d    = state_q;
    hdr_d      = hdr_q;
    cnt_d      = cnt_q;
    ack_d      = ack_q;
    dout_d     = dout_q;
    err_d      = err_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;

    case (state_q)
      StIdle: begin
        if (stb_edge) begin
          hdr_d = din_i;
          if (|din_i[6:2]) begin
            err_d   = 1'b1;
            ack_d   = 1'b1;
            state_d = StAckHdr;
          end else if (din_i[7]) begin
            err_d   = 1'b0;
            ack_d   = 1'b1;
            state_d = StAckHdr;
          end else begin
            state_d = StRdFetch;
          end
        end
      end
      StRdFetch: begin
        dout_d  = rd_data_i;
        err_d   = 1'b0;
        ack_d   = 1'b1;
        state_d = StAckRd;
      end
      StAckRd, StAckData: begin
        if (!stb_s) begin
          ack_d   = 1'b0;
          state_d = StIdle;
        end
      end
      StAckHdr: begin
        if (!stb_s) begin
          ack_d = 1'b0;
          if (hdr_is_write) begin
            cnt_d   = 8'd0;
            state_d = StWaitData;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StWaitData: begin
        // A strobe edge in the timeout cycle still completes the write.
        if (stb_edge) begin
          wr_en_d   = 1'b1;
          wr_addr_d = hdr_q[1:0];
          wr_data_d = din_i;
          ack_d     = 1'b1;
          state_d   = StAckData;
        end else if (cnt_q == TimeoutCnt) begin
          err_d   = 1'b1;
          state_d = StIdle;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q     <= '0;
      fill_q     <= '0;
      stb_prev_q <= 1'b0;
      armed_q    <= 1'b0;
      state_q    <= StIdle;
      hdr_q      <= 8'd0;
      cnt_q      <= 8'd0;
      ack_q      <= 1'b0;
      dout_q     <= 8'd0;
      err_q      <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= 2'd0;
      wr_data_q  <= 8'd0;
    end else begin
      sync_q     <= {sync_q[SYNC_STAGES-2:0], stb_i};
      fill_q     <= {fill_q[SYNC_STAGES-2:0], 1'b1};
      stb_prev_q <= stb_prev_d;
      armed_q    <= armed_d;
      state_q    <= state_d;
      hdr_q      <= hdr_d;
      cnt_q      <= cnt_d;
      ack_q      <= ack_d;
      dout_q     <= dout_d;
      err_q      <= err_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
    end
  end

  assign ack_o     = ack_q;
  assign dout_o    = dout_q;
  assign err_o     = err_q;
  assign wr_en_o   = wr_en_q;
  assign wr_addr_o = wr_addr_q;
  assign wr_data_o = wr_data_q;
  assign rd_addr_o = (state_q == StRdFetch) ? hdr_q[1:0] : 2'd0;

endmodule

// File: tb/tb_tophat_pin_responder.sv
// Self-checking bench for tophat_pin_responder: drives host byte handshakes with exact cycle
// timing, models the core register file, and scoreboards writes and reads through queues.
module tb_tophat_pin_responder;

  localparam int SYNC = 2;
  localparam int TMO  = 16;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] din_i;
  logic       stb_i;
  logic       ack_o;
  logic [7:0] dout_o;
  logic       err_o;
  logic       wr_en_o;
  logic [1:0] wr_addr_o;
  logic [7:0] wr_data_o;
  logic [1:0] rd_addr_o;
  logic [7:0] rd_data_i;

  int n_checks  = 0;
  int n_fail    = 0;
  int wr_pulses = 0;

  logic [9:0] exp_wr_q[$];
  logic [7:0] exp_rd_q[$];

  tophat_pin_responder #(
    .SYNC_STAGES(SYNC),
    .TIMEOUT    (TMO)
  ) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .din_i    (din_i),
    .stb_i    (stb_i),
    .ack_o    (ack_o),
    .dout_o   (dout_o),
    .err_o    (err_o),
    .wr_en_o  (wr_en_o),
    .wr_addr_o(wr_addr_o),
    .wr_data_o(wr_data_o),
    .rd_addr_o(rd_addr_o),
    .rd_data_i(rd_data_i)
  );

  always #5 clk_i = ~clk_i;

  // Core register file model.
  always_comb begin
    case (rd_addr_o)
      2'd0:    rd_data_i = 8'h11;
      2'd1:    rd_data_i = 8'hC3;
      2'd2:    rd_data_i = 8'h3C;
      default: rd_data_i = 8'h96;
    endcase
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  // Write scoreboard: every wr_en pulse must match the oldest pushed write.
  always @(negedge clk_i) begin
    if (wr_en_o === 1'b1) begin
      logic [9:0] e;
      wr_pulses++;
      check_eq("wr_expected", 32'(exp_wr_q.size() > 0), 32'd1);
      if (exp_wr_q.size() > 0) begin
        e = exp_wr_q.pop_front();
        check_eq("wr_addr", 32'(wr_addr_o), 32'(e[9:8]));
        check_eq("wr_data", 32'(wr_data_o), 32'(e[7:0]));
      end
    end
  end

  // One full host handshake. lat: ack expected at edge cycle N+lat. Returns in the cycle
  // where ack has just fallen.
  task automatic host_byte(input logic [7:0] b, input int lat, input logic exp_wr,
                           input logic is_read);
    din_i = b;
    repeat (SYNC + 1) tick();
    stb_i = 1'b1;
    for (int k = 1; k <= SYNC + lat; k++) begin
      tick();
      if (k == SYNC + lat - 1) check_eq("ack_early", 32'(ack_o), 32'd0);
      if (is_read && k == SYNC + 1) check_eq("rd_addr", 32'(rd_addr_o), 32'(b[1:0]));
      if (k == SYNC + lat) begin
        check_eq("ack_rise", 32'(ack_o), 32'd1);
        check_eq("wr_en_at_ack", 32'(wr_en_o), 32'(exp_wr));
        if (is_read) begin
          logic [7:0] e;
          check_eq("rd_expected", 32'(exp_rd_q.size() > 0), 32'd1);
          e = (exp_rd_q.size() > 0) ? exp_rd_q.pop_front() : 8'h00;
          check_eq("dout", 32'(dout_o), 32'(e));
        end
      end
    end
    stb_i = 1'b0;
    repeat (SYNC) tick();
    check_eq("ack_hold", 32'(ack_o), 32'd1);
    tick();
    check_eq("ack_fall", 32'(ack_o), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_ack"},     32'(ack_o),     32'd0);
    check_eq({tag, "_dout"},    32'(dout_o),    32'd0);
    check_eq({tag, "_err"},     32'(err_o),     32'd0);
    check_eq({tag, "_wr_en"},   32'(wr_en_o),   32'd0);
    check_eq({tag, "_wr_addr"}, 32'(wr_addr_o), 32'd0);
    check_eq({tag, "_wr_data"}, 32'(wr_data_o), 32'd0);
    check_eq({tag, "_rd_addr"}, 32'(rd_addr_o), 32'd0);
  endtask

  initial begin
    logic seen_ack;
    // Strobe held high through reset must never produce a command.
    rst_i = 1'b1;
    stb_i = 1'b1;
    din_i = 8'h82;
    repeat (3) tick();
    check_reset_values("rst");
    rst_i    = 1'b0;
    seen_ack = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      seen_ack |= ack_o;
    end
    stb_i = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      seen_ack |= ack_o;
    end
    check_eq("stuck_stb_ack", 32'(seen_ack), 32'd0);
    check_eq("stuck_stb_err", 32'(err_o), 32'd0);

    // Write header then data byte to address 2.
    host_byte(8'h82, 1, 1'b0, 1'b0);
    check_eq("wr_hdr_err", 32'(err_o), 32'd0);
    exp_wr_q.push_back({2'd2, 8'h5A});
    host_byte(8'h5A, 1, 1'b1, 1'b0);
    check_eq("wr_data_err", 32'(err_o), 32'd0);

    // Reads: dout must hold after the handshake closes.
    exp_rd_q.push_back(8'hC3);
    host_byte(8'h01, 2, 1'b0, 1'b1);
    repeat (3) tick();
    check_eq("dout_hold", 32'(dout_o), 32'hC3);
    check_eq("rd_err", 32'(err_o), 32'd0);
    exp_rd_q.push_back(8'h3C);
    host_byte(8'h02, 2, 1'b0, 1'b1);

    // Reserved bit set: error ack, next byte is a fresh header that clears err.
    host_byte(8'h24, 1, 1'b0, 1'b0);
    check_eq("rsvd_err", 32'(err_o), 32'd1);
    exp_rd_q.push_back(8'h96);
    host_byte(8'h03, 2, 1'b0, 1'b1);
    check_eq("rsvd_clear_err", 32'(err_o), 32'd0);

    // Write header with no data: abort TMO+1 cycles after entering the wait.
    host_byte(8'h80, 1, 1'b0, 1'b0);
    repeat (TMO) tick();
    check_eq("tmo_err_early", 32'(err_o), 32'd0);
    tick();
    check_eq("tmo_err", 32'(err_o), 32'd1);
    check_eq("tmo_ack", 32'(ack_o), 32'd0);
    exp_rd_q.push_back(8'hC3);
    host_byte(8'h01, 2, 1'b0, 1'b1);
    check_eq("tmo_idle_err", 32'(err_o), 32'd0);

    // Reset mid-write: outputs return to reset, the following byte is a header (reserved
    // bits set -> error), and nothing is written.
    host_byte(8'h83, 1, 1'b0, 1'b0);
    repeat (2) tick();
    rst_i = 1'b1;
    tick();
    check_reset_values("midrst");
    rst_i = 1'b0;
    repeat (4) tick();
    host_byte(8'hA5, 1, 1'b0, 1'b0);
    check_eq("midrst_err", 32'(err_o), 32'd1);

    repeat (4) tick();
    check_eq("wr_pulses", 32'(wr_pulses), 32'd1);
    check_eq("wr_queue_empty", 32'(exp_wr_q.size()), 32'd0);
    check_eq("rd_queue_empty", 32'(exp_rd_q.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
